// File: rtl/sfifo_pkg.sv
// Shared constants and helpers for the sfifo_prm FIFO family.
package sfifo_pkg;

  localparam int DEF_WIDTH  = 8;
  localparam int DEF_DEPTH  = 16;
  localparam int DEF_AE_LVL = 2;

  // Ceiling log2, usable in parameter and port declarations.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction

endpackage

// File: rtl/sfifo_prm_mem.sv
// DEPTH x WIDTH storage array for sfifo_prm: one synchronous write port,
// one combinational read port. Contents are never reset.
module sfifo_prm_mem
  import sfifo_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DEPTH = DEF_DEPTH
) (
  input  logic                      clk,
  input  logic                      w_en,
  input  logic [clog2(DEPTH)-1:0]   waddr,
  input  logic [WIDTH-1:0]          wdata,
  input  logic [clog2(DEPTH)-1:0]   raddr,
  output logic [WIDTH-1:0]          rdata
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (w_en) mem_q[waddr] <= wdata;
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/sfifo_prm.sv
// Synchronous FIFO with level, almost flags and sticky error flags.
// Define SFIFO_FWFT_EN for first-word-fall-through output; default is registered read.
module sfifo_prm
  import sfifo_pkg::*;
#(
  parameter int WIDTH  = DEF_WIDTH,
  parameter int DEPTH  = DEF_DEPTH,
  parameter int AF_LVL = DEPTH - 2,
  parameter int AE_LVL = DEF_AE_LVL
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    w_en,
  input  logic [WIDTH-1:0]        din,
  input  logic                    r_en,
  input  logic                    flush,
  input  logic                    clr_err,
  output logic [WIDTH-1:0]        dout,
  output logic                    full,
  output logic                    empty,
  output logic                    almost_full,
  output logic                    almost_empty,
  output logic [clog2(DEPTH):0]   level,
  output logic                    overflow,
  output logic                    underflow
);

  localparam int            AW      = clog2(DEPTH);
  localparam logic [AW:0]   PTR_ONE = (AW+1)'(1);
  localparam logic [AW:0]   AF_THR  = (AW+1)'(AF_LVL);
  localparam logic [AW:0]   AE_THR  = (AW+1)'(AE_LVL);

  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic [AW:0]      level_q, level_d;
  logic [WIDTH-1:0] dout_q, dout_d;
  logic             ovf_q, ovf_d;
  logic             unf_q, unf_d;
  logic [WIDTH-1:0] mem_rdata;
  logic             full_w, empty_w;
  logic             wr_acc, rd_acc, ovf_set, unf_set;

  // Extra pointer MSB distinguishes full (MSBs differ) from empty (all equal).
  assign full_w  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign empty_w = (wr_ptr_q == rd_ptr_q);

  always_comb begin
    rd_acc   = r_en && !empty_w && !flush;
    wr_acc   = w_en && (!full_w || rd_acc) && !flush;
    ovf_set  = w_en && !wr_acc && !flush;
    unf_set  = r_en && !rd_acc && !flush;

    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    dout_d   = dout_q;

    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
    end else begin
      if (wr_acc) wr_ptr_d = wr_ptr_q + PTR_ONE;
      if (rd_acc) begin
        rd_ptr_d = rd_ptr_q + PTR_ONE;
        dout_d   = mem_rdata;
      end
      case ({wr_acc, rd_acc})
        2'b10:   level_d = level_q + PTR_ONE;
        2'b01:   level_d = level_q - PTR_ONE;
        default: level_d = level_q;
      endcase
    end

    // A fresh error outranks a clear in the same cycle.
    ovf_d = (ovf_q && !clr_err) || ovf_set;
    unf_d = (unf_q && !clr_err) || unf_set;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      dout_q   <= '0;
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      dout_q   <= dout_d;
      ovf_q    <= ovf_d;
      unf_q    <= unf_d;
    end
  end

  sfifo_prm_mem #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_mem (
    .clk   (clk),
    .w_en  (wr_acc),
    .waddr (wr_ptr_q[AW-1:0]),
    .wdata (din),
    .raddr (rd_ptr_q[AW-1:0]),
    .rdata (mem_rdata)
  );

`ifdef SFIFO_FWFT_EN
  // Head word is visible whenever data is present; otherwise hold the last pop.
  assign dout = empty_w ? dout_q : mem_rdata;
`else
  assign dout = dout_q;
`endif

  assign full         = full_w;
  assign empty        = empty_w;
  assign almost_full  = (level_q >= AF_THR);
  assign almost_empty = (level_q <= AE_THR);
  assign level        = level_q;
  assign overflow     = ovf_q;
  assign underflow    = unf_q;

endmodule

// File: tb/tb_sfifo_prm.sv
// Directed self-checking bench for sfifo_prm (default parameters, either build).
module tb_sfifo_prm;

  logic       clk;
  logic       rst;
  logic       w_en;
  logic [7:0] din;
  logic       r_en;
  logic       flush;
  logic       clr_err;
  logic [7:0] dout;
  logic       full, empty, almost_full, almost_empty;
  logic [4:0] level;
  logic       overflow, underflow;

  int tests;
  int failed;

  sfifo_prm u_dut (
    .clk          (clk),
    .rst          (rst),
    .w_en         (w_en),
    .din          (din),
    .r_en         (r_en),
    .flush        (flush),
    .clr_err      (clr_err),
    .dout         (dout),
    .full         (full),
    .empty        (empty),
    .almost_full  (almost_full),
    .almost_empty (almost_empty),
    .level        (level),
    .overflow     (overflow),
    .underflow    (underflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic applyStimulus(input logic w, input logic [7:0] d, input logic r,
                               input logic f, input logic c);
    w_en    = w;
    din     = d;
    r_en    = r;
    flush   = f;
    clr_err = c;
    @(posedge clk);
    #1;
    w_en    = 1'b0;
    r_en    = 1'b0;
    flush   = 1'b0;
    clr_err = 1'b0;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      failed++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic checkResetState(input string tag);
    checkOutput({tag, "_level"}, 32'(level), 32'd0);
    checkOutput({tag, "_empty"}, 32'(empty), 32'd1);
    checkOutput({tag, "_aempty"}, 32'(almost_empty), 32'd1);
    checkOutput({tag, "_full"}, 32'(full), 32'd0);
    checkOutput({tag, "_afull"}, 32'(almost_full), 32'd0);
    checkOutput({tag, "_ovf"}, 32'(overflow), 32'd0);
    checkOutput({tag, "_unf"}, 32'(underflow), 32'd0);
    checkOutput({tag, "_dout"}, 32'(dout), 32'd0);
  endtask

  initial begin
    logic [7:0] exp_v;
    tests   = 0;
    failed  = 0;
    rst     = 1'b0;
    w_en    = 1'b0;
    din     = 8'h00;
    r_en    = 1'b0;
    flush   = 1'b0;
    clr_err = 1'b0;

    repeat (2) @(posedge clk);
    #1;
    checkResetState("reset");
    rst = 1'b1;

    // Fill to full with 0x75..0x84
    for (int i = 0; i < 16; i++) begin
      applyStimulus(1'b1, 8'(8'h75 + i), 1'b0, 1'b0, 1'b0);
      checkOutput($sformatf("fill_level_%0d", i), 32'(level), 32'(i + 1));
      checkOutput($sformatf("fill_full_%0d", i), 32'(full), 32'(i == 15));
      checkOutput($sformatf("fill_afull_%0d", i), 32'(almost_full), 32'(i + 1 >= 14));
      checkOutput($sformatf("fill_aempty_%0d", i), 32'(almost_empty), 32'(i + 1 <= 2));
      checkOutput($sformatf("fill_empty_%0d", i), 32'(empty), 32'd0);
    end

    applyStimulus(1'b1, 8'h99, 1'b0, 1'b0, 1'b0);
    checkOutput("overflow_set", 32'(overflow), 32'd1);
    checkOutput("overflow_level", 32'(level), 32'd16);
    checkOutput("overflow_full", 32'(full), 32'd1);

    // Drain; rejected 0x99 must not appear
    for (int k = 0; k < 16; k++) begin
`ifdef SFIFO_FWFT_EN
      checkOutput($sformatf("drain_head_%0d", k), 32'(dout), 32'(8'h75 + k));
`endif
      applyStimulus(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
`ifndef SFIFO_FWFT_EN
      checkOutput($sformatf("drain_dout_%0d", k), 32'(dout), 32'(8'h75 + k));
`endif
      checkOutput($sformatf("drain_level_%0d", k), 32'(level), 32'(15 - k));
    end
    checkOutput("drain_empty", 32'(empty), 32'd1);
    checkOutput("drain_full", 32'(full), 32'd0);

    applyStimulus(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    checkOutput("underflow_set", 32'(underflow), 32'd1);
    checkOutput("underflow_ovf_sticky", 32'(overflow), 32'd1);
    checkOutput("underflow_level", 32'(level), 32'd0);
    checkOutput("underflow_dout_hold", 32'(dout), 32'h84);

    applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    checkOutput("clr_ovf", 32'(overflow), 32'd0);
    checkOutput("clr_unf", 32'(underflow), 32'd0);

    // Pointer wrap: 40 write/read pairs, data 0xF0..0x17
    for (int k = 0; k < 40; k++) begin
      exp_v = 8'(8'hF0 + k);
      applyStimulus(1'b1, exp_v, 1'b0, 1'b0, 1'b0);
      checkOutput($sformatf("wrap_wlevel_%0d", k), 32'(level), 32'd1);
      checkOutput($sformatf("wrap_wfull_%0d", k), 32'(full), 32'd0);
`ifdef SFIFO_FWFT_EN
      checkOutput($sformatf("wrap_head_%0d", k), 32'(dout), 32'(exp_v));
`endif
      applyStimulus(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
      checkOutput($sformatf("wrap_dout_%0d", k), 32'(dout), 32'(exp_v));
      checkOutput($sformatf("wrap_rempty_%0d", k), 32'(empty), 32'd1);
    end
    checkOutput("wrap_no_errors", 32'({overflow, underflow}), 32'd0);

    // Simultaneous write+read while empty
    applyStimulus(1'b1, 8'h3C, 1'b1, 1'b0, 1'b0);
    checkOutput("sim_empty_level", 32'(level), 32'd1);
    checkOutput("sim_empty_unf", 32'(underflow), 32'd1);
    checkOutput("sim_empty_ovf", 32'(overflow), 32'd0);
    checkOutput("sim_empty_empty", 32'(empty), 32'd0);
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    checkOutput("sim_empty_clr", 32'(underflow), 32'd0);

    for (int i = 0; i < 15; i++) applyStimulus(1'b1, 8'(8'h40 + i), 1'b0, 1'b0, 1'b0);
    checkOutput("refill_full", 32'(full), 32'd1);

    // Simultaneous write+read while full: head 0x3C pops, 0x5A enters
    applyStimulus(1'b1, 8'h5A, 1'b1, 1'b0, 1'b0);
    checkOutput("sim_full_level", 32'(level), 32'd16);
    checkOutput("sim_full_full", 32'(full), 32'd1);
    checkOutput("sim_full_ovf", 32'(overflow), 32'd0);
`ifdef SFIFO_FWFT_EN
    checkOutput("sim_full_head", 32'(dout), 32'h40);
`else
    checkOutput("sim_full_dout", 32'(dout), 32'h3C);
`endif

    for (int i = 0; i < 7; i++) applyStimulus(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    checkOutput("pre_flush_level", 32'(level), 32'd9);

    // Flush at level 9 with requests active
    applyStimulus(1'b1, 8'hEE, 1'b1, 1'b1, 1'b0);
    checkOutput("flush_level", 32'(level), 32'd0);
    checkOutput("flush_empty", 32'(empty), 32'd1);
    checkOutput("flush_full", 32'(full), 32'd0);
    checkOutput("flush_aempty", 32'(almost_empty), 32'd1);
    checkOutput("flush_errs", 32'({overflow, underflow}), 32'd0);
    checkOutput("flush_dout_hold", 32'(dout), 32'h46);

    applyStimulus(1'b1, 8'h11, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 8'h22, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 8'h33, 1'b0, 1'b0, 1'b0);
`ifdef SFIFO_FWFT_EN
    checkOutput("post_flush_head", 32'(dout), 32'h11);
`endif
    applyStimulus(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    checkOutput("post_flush_dout", 32'(dout), 32'h11);
    checkOutput("post_flush_level", 32'(level), 32'd2);

    // Asynchronous reset pulse mid-stream
    #2;
    rst = 1'b0;
    #1;
    checkResetState("mid_reset");
    @(posedge clk);
    #1;
    rst = 1'b1;

    applyStimulus(1'b1, 8'h77, 1'b0, 1'b0, 1'b0);
    checkOutput("resume_level", 32'(level), 32'd1);
    applyStimulus(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    checkOutput("resume_dout", 32'(dout), 32'h77);
    checkOutput("resume_empty", 32'(empty), 32'd1);

    // Write into empty FIFO with no read request
    applyStimulus(1'b1, 8'hA5, 1'b0, 1'b0, 1'b0);
`ifdef SFIFO_FWFT_EN
    checkOutput("fwft_dout", 32'(dout), 32'hA5);
`else
    checkOutput("std_dout_hold", 32'(dout), 32'h77);
`endif
    checkOutput("final_level", 32'(level), 32'd1);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
